// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared ALU control constants and controller state encoding
package alu_share_ctrl_pkg;

   // Hack ALU control words, ordered {zx,nx,zy,ny,f,no}
   localparam logic [5:0] CTL_ZERO    = 6'b101010;
   localparam logic [5:0] CTL_ONE     = 6'b111111;
   localparam logic [5:0] CTL_NEG1    = 6'b111010;
   localparam logic [5:0] CTL_X       = 6'b001100;
   localparam logic [5:0] CTL_XPLUSY  = 6'b000010;
   localparam logic [5:0] CTL_XMINUSY = 6'b010011;
   localparam logic [5:0] CTL_XANDY   = 6'b000000;
   localparam logic [5:0] CTL_XORY    = 6'b010101;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-way round-robin or fixed-priority grant
module rr_arb2 #(
   parameter int RR = 1
) (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   input  logic enable,
   output logic grant0,
   output logic grant1
);

   logic pick1;

   // Requester 1 wins when alone, or on a tie when round-robin says it is its turn
   assign pick1  = valid1 & (~valid0 | ((RR != 0) & ~last_grant));
   assign grant1 = enable & pick1;
   assign grant0 = enable & valid0 & ~pick1;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one external Hack ALU between two requesters
// Optional statistics counters are enabled by defining ALU_SHARE_STATS_EN.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CTL_W = 6,
   parameter int RR    = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   input  logic [CTL_W-1:0] req0_ctl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   input  logic [CTL_W-1:0] req1_ctl,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [CTL_W-1:0] alu_ctl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_zr,
   output logic             rsp_ng,
`ifdef ALU_SHARE_STATS_EN
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1,
   output logic [15:0]      stall_cnt,
`endif
   output logic             rsp_id
);

   state_t state;
   logic   last_grant;
   logic   can_issue;
   logic   grant0;
   logic   grant1;
   logic   hs;

   // A held response being taken frees the register for a same-cycle refill
   assign can_issue = (state == IDLE) | (rsp_valid & rsp_ready);

   rr_arb2 #(.RR(RR)) u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .enable     (can_issue),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign hs         = grant0 | grant1;

   assign alu_x   = grant1 ? req1_x   : req0_x;
   assign alu_y   = grant1 ? req1_y   : req0_y;
   assign alu_ctl = grant1 ? req1_ctl : req0_ctl;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         rsp_valid  <= 1'b0;
         rsp_out    <= '0;
         rsp_zr     <= 1'b0;
         rsp_ng     <= 1'b0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
      end else if (hs) begin
         state      <= HOLD;
         rsp_valid  <= 1'b1;
         rsp_out    <= alu_out;
         rsp_zr     <= alu_zr;
         rsp_ng     <= alu_ng;
         rsp_id     <= grant1;
         last_grant <= grant1;
      end else if (state == HOLD && rsp_ready) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
      end
   end

`ifdef ALU_SHARE_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
         stall_cnt  <= 16'd0;
      end else begin
         if (grant0) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (grant1) grant_cnt1 <= grant_cnt1 + 16'd1;
         if ((req0_valid | req1_valid) & ~hs) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed bench for alu_share_ctrl with a behavioural Hack ALU
// Exercises the stats counters when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;
   import alu_share_ctrl_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
   logic [15:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
   logic [5:0]  req0_ctl = 0, req1_ctl = 0;
   logic        req0_ready, req1_ready, rsp_valid, rsp_zr, rsp_ng, rsp_id;
   logic [15:0] alu_x, alu_y, alu_out, rsp_out;
   logic [5:0]  alu_ctl;
   logic        alu_zr, alu_ng;

   logic        f0_valid = 0, f1_valid = 0, f_rsp_ready = 0;
   logic        f0_ready, f1_ready, f_rsp_valid, f_rsp_zr, f_rsp_ng, f_rsp_id;
   logic [15:0] f_alu_x, f_alu_y, f_alu_out, f_rsp_out;
   logic [5:0]  f_alu_ctl;
   logic        f_alu_zr, f_alu_ng;
`ifdef ALU_SHARE_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, stall_cnt, f_gc0, f_gc1, f_sc;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   function automatic logic [17:0] hack(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
      logic [15:0] a, b, o;
      a = c[5] ? 16'd0 : x;
      a = c[4] ? ~a : a;
      b = c[3] ? 16'd0 : y;
      b = c[2] ? ~b : b;
      o = c[1] ? a + b : a & b;
      o = c[0] ? ~o : o;
      return {(o == 16'd0), o[15], o};
   endfunction

   assign {alu_zr, alu_ng, alu_out}       = hack(alu_x, alu_y, alu_ctl);
   assign {f_alu_zr, f_alu_ng, f_alu_out} = hack(f_alu_x, f_alu_y, f_alu_ctl);

   alu_share_ctrl #(.WIDTH(16), .CTL_W(6), .RR(1)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_ctl(req0_ctl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_ctl(req1_ctl),
      .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng),
`ifdef ALU_SHARE_STATS_EN
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
      .rsp_id(rsp_id)
   );

   alu_share_ctrl #(.WIDTH(16), .CTL_W(6), .RR(0)) dut_fp (
      .clock(clock), .reset(reset),
      .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_x(16'd9), .req0_y(16'd1), .req0_ctl(CTL_XPLUSY),
      .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_x(16'd2), .req1_y(16'd2), .req1_ctl(CTL_XPLUSY),
      .alu_x(f_alu_x), .alu_y(f_alu_y), .alu_ctl(f_alu_ctl), .alu_out(f_alu_out), .alu_zr(f_alu_zr), .alu_ng(f_alu_ng),
      .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_out(f_rsp_out), .rsp_zr(f_rsp_zr), .rsp_ng(f_rsp_ng),
`ifdef ALU_SHARE_STATS_EN
      .grant_cnt0(f_gc0), .grant_cnt1(f_gc1), .stall_cnt(f_sc),
`endif
      .rsp_id(f_rsp_id)
   );

   // Requester protocol: fields and valid must hold while valid & ~ready
   logic        p0 = 0, p1 = 0;
   logic [37:0] s0, s1;
   always @(negedge clock) begin
      if (!reset && p0)
         assert (req0_valid && {req0_x, req0_y, req0_ctl} == s0)
            else begin bad++; $display("FAIL hold0: req0 changed while stalled"); end
      if (!reset && p1)
         assert (req1_valid && {req1_x, req1_y, req1_ctl} == s1)
            else begin bad++; $display("FAIL hold1: req1 changed while stalled"); end
      p0 <= !reset && req0_valid && !req0_ready;
      p1 <= !reset && req1_valid && !req1_ready;
      s0 <= {req0_x, req0_y, req0_ctl};
      s1 <= {req1_x, req1_y, req1_ctl};
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic reset_dut();
      req0_valid = 0; req1_valid = 0; f0_valid = 0; f1_valid = 0;
      reset = 1;
      cyc();
      cyc();
      reset = 0;
   endtask

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [5:0]  ctl;
      logic [15:0] out;
      logic        zr;
      logic        ng;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{16'd5,     16'd3,     CTL_XPLUSY,  16'd8,     1'b0, 1'b0};
      vt[1] = '{16'd10,    16'd4,     CTL_XMINUSY, 16'd6,     1'b0, 1'b0};
      vt[2] = '{16'd4,     16'd10,    CTL_XMINUSY, 16'hFFFA,  1'b0, 1'b1};
      vt[3] = '{16'h1234,  16'h5678,  CTL_ZERO,    16'h0000,  1'b1, 1'b0};
      vt[4] = '{16'h1234,  16'h5678,  CTL_ONE,     16'h0001,  1'b0, 1'b0};
      vt[5] = '{16'h1234,  16'h5678,  CTL_NEG1,    16'hFFFF,  1'b0, 1'b1};
      vt[6] = '{16'h1234,  16'h5678,  CTL_X,       16'h1234,  1'b0, 1'b0};
      vt[7] = '{16'hF0F0,  16'h0FF0,  CTL_XANDY,   16'h00F0,  1'b0, 1'b0};
      vt[8] = '{16'hF0F0,  16'h0FF0,  CTL_XORY,    16'hFFF0,  1'b0, 1'b1};
      vt[9] = '{16'h7FFF,  16'h0001,  CTL_XPLUSY,  16'h8000,  1'b0, 1'b1};

      reset_dut();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_out",   rsp_out, 0);
      chk("rst_zr",    rsp_zr, 0);
      chk("rst_id",    rsp_id, 0);
      chk("rst_rdy0",  req0_ready, 0);

      // Single-requester vectors, one op each with 1-cycle latency
      for (int i = 0; i < 10; i++) begin
         req0_x = vt[i].x; req0_y = vt[i].y; req0_ctl = vt[i].ctl;
         req0_valid = 1; rsp_ready = 1;
         #1;
         chk($sformatf("v%0d_rdy", i), req0_ready, 1);
         cyc();
         req0_valid = 0;
         chk($sformatf("v%0d_valid", i), rsp_valid, 1);
         chk($sformatf("v%0d_out", i), rsp_out, vt[i].out);
         chk($sformatf("v%0d_zr", i),  rsp_zr, vt[i].zr);
         chk($sformatf("v%0d_ng", i),  rsp_ng, vt[i].ng);
         chk($sformatf("v%0d_id", i),  rsp_id, 0);
      end
      cyc();
      chk("drain_valid", rsp_valid, 0);

      // Round-robin alternation under sustained contention
      reset_dut();
      req0_x = 10; req0_y = 4;  req0_ctl = CTL_XMINUSY;
      req1_x = 4;  req1_y = 10; req1_ctl = CTL_XMINUSY;
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr%0d_rdy0", i), req0_ready, (i % 2 == 0));
         chk($sformatf("rr%0d_rdy1", i), req1_ready, (i % 2 == 1));
         cyc();
         chk($sformatf("rr%0d_valid", i), rsp_valid, 1);
         chk($sformatf("rr%0d_out", i), rsp_out, (i % 2 == 0) ? 16'd6 : 16'hFFFA);
         chk($sformatf("rr%0d_ng", i),  rsp_ng, (i % 2 == 1));
         chk($sformatf("rr%0d_id", i),  rsp_id, (i % 2 == 1));
      end
      req0_valid = 0; req1_valid = 0;

      // Backpressure: held zero result, then same-cycle refill on release
      reset_dut();
      req0_x = 16'h55; req0_y = 16'h66; req0_ctl = CTL_ZERO;
      req0_valid = 1; rsp_ready = 1;
      #1;
      chk("bp_rdy0", req0_ready, 1);
      cyc();
      req0_valid = 0; rsp_ready = 0;
      req1_x = 1; req1_y = 2; req1_ctl = CTL_XPLUSY; req1_valid = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_valid", i), rsp_valid, 1);
         chk($sformatf("bp%0d_out", i), rsp_out, 0);
         chk($sformatf("bp%0d_zr", i), rsp_zr, 1);
         chk($sformatf("bp%0d_rdy", i), {req0_ready, req1_ready}, 0);
         cyc();
      end
      rsp_ready = 1;
      #1;
      chk("bp_release_rdy1", req1_ready, 1);
      cyc();
      req1_valid = 0;
      chk("bp_out", rsp_out, 3);
      chk("bp_id", rsp_id, 1);
      chk("bp_zr", rsp_zr, 0);

      // Reset while holding discards the response and restores req0 priority
      reset_dut();
      req0_x = 7; req0_y = 0; req0_ctl = CTL_X; req0_valid = 1; rsp_ready = 0;
      #1;
      chk("rh_rdy0", req0_ready, 1);
      cyc();
      req0_valid = 0;
      chk("rh_held", rsp_out, 7);
      cyc();
      reset = 1;
      cyc();
      reset = 0;
      chk("rh_valid", rsp_valid, 0);
      chk("rh_out", rsp_out, 0);
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      #1;
      chk("rh_rdy0_first", req0_ready, 1);
      chk("rh_rdy1_first", req1_ready, 0);
      cyc();
      req0_valid = 0; req1_valid = 0;
      chk("rh_id", rsp_id, 0);

      // Fixed priority instance: req1 starves until req0 drops
      reset_dut();
      f0_valid = 1; f1_valid = 1; f_rsp_ready = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("fp%0d_rdy0", i), f0_ready, 1);
         chk($sformatf("fp%0d_rdy1", i), f1_ready, 0);
         cyc();
         chk($sformatf("fp%0d_out", i), f_rsp_out, 10);
         chk($sformatf("fp%0d_id", i), f_rsp_id, 0);
      end
      f0_valid = 0;
      #1;
      chk("fp_rdy1", f1_ready, 1);
      cyc();
      f1_valid = 0;
      chk("fp_out1", f_rsp_out, 4);
      chk("fp_id1", f_rsp_id, 1);

`ifdef ALU_SHARE_STATS_EN
      reset_dut();
      chk("st_rst_stall", stall_cnt, 0);
      req0_x = 1; req0_y = 1; req0_ctl = CTL_XPLUSY; req0_valid = 1; rsp_ready = 0;
      cyc();
      req0_valid = 0;
      req1_x = 3; req1_y = 3; req1_ctl = CTL_XPLUSY; req1_valid = 1;
      cyc();
      cyc();
      chk("st_stall2", stall_cnt, 2);
      rsp_ready = 1;
      cyc();
      req1_valid = 0;
      chk("st_gc0", grant_cnt0, 1);
      chk("st_gc1", grant_cnt1, 1);

      reset_dut();
      req1_valid = 1; rsp_ready = 1;
      repeat (65535) cyc();
      chk("st_gc1_max", grant_cnt1, 16'hFFFF);
      cyc();
      req1_valid = 0;
      chk("st_gc1_wrap", grant_cnt1, 0);
      chk("st_gc0_zero", grant_cnt0, 0);
`endif

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Controller that shares one combinational 16-bit Hack ALU (zx,nx,zy,ny,f,no control) between two requesters.
- Each requester sends x, y and 6-bit control with a valid/ready handshake.
- The block grants one request per cycle by round-robin, drives the shared ALU, and registers the result plus zr/ng flags for a single response channel tagged with the requester id.
- Sits between the CPU-side datapath clients (e.g. address unit, main datapath) and the ALU instance.

Parameters:
- WIDTH, 16, data width of x, y and result.
- CTL_W, 6, ALU control width, ordered {zx,nx,zy,ny,f,no}, bit 5 = zx.
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_x  in  WIDTH  operand x
- req0_y  in  WIDTH  operand y
- req0_ctl  in  CTL_W  ALU control
- req1_valid / req1_ready / req1_x / req1_y / req1_ctl  same as requester 0
- alu_x  out  WIDTH  operand to shared ALU
- alu_y  out  WIDTH  operand to shared ALU
- alu_ctl  out  CTL_W  control to shared ALU
- alu_out  in  WIDTH  ALU result, combinational from alu_x/alu_y/alu_ctl
- alu_zr  in  1  ALU zero flag
- alu_ng  in  1  ALU negative flag
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_out  out  WIDTH  registered result
- rsp_zr  out  1  registered zero flag
- rsp_ng  out  1  registered negative flag
- rsp_id  out  1  requester that issued the response

Behaviour:
- Reset (synchronous, active-high, wins over everything): state IDLE, rsp_valid=0, rsp_out=0, rsp_zr=0, rsp_ng=0, rsp_id=0, last_grant=1 (requester 0 has first priority).
- States are IDLE (no response held) and HOLD (response held, rsp_valid=1).
- can_issue = (state==IDLE) | (rsp_valid & rsp_ready).
- Grant is combinational:
  - RR=1: if both valid, winner = ~last_grant; else the sole valid requester.
  - RR=0: requester 0 wins whenever it is valid.
- reqN_ready = can_issue & grant==N & reqN_valid. At most one ready is high per cycle.
- alu_x/alu_y/alu_ctl mux the granted requester's fields. With no grant they present requester 0's fields (don't-care to consumers).
- On a handshake edge (any reqN_valid & reqN_ready):
  - alu_out, alu_zr and alu_ng are captured into rsp_out, rsp_zr and rsp_ng.
  - rsp_id <= N, last_grant <= N, state <= HOLD.
  - Latency: request accepted in cycle t produces rsp_valid=1 in cycle t+1.
- HOLD with rsp_ready=1 and no new grant: state <= IDLE, rsp_valid <= 0. The rsp_out/zr/ng/id registers keep their values.
- HOLD with rsp_ready=1 and a new grant in the same cycle: the response register is overwritten and state stays HOLD. Sustained throughput is 1 op/cycle.
- HOLD with rsp_ready=0: no ready asserted, and all response outputs are stable until taken.
- Requesters may not drop valid or change fields while valid & ~ready. A bench assertion checks this.
- last_grant updates only on a handshake, never on an idle cycle.
- Reset asserted while in HOLD: the held response is discarded and rsp_valid=0 on the next cycle.

Optional Feature:
- ALU_SHARE_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), reset to 0.
  - Each increments on its requester's handshake and wraps 0xFFFF -> 0x0000.
  - Adds output stall_cnt (16 bits), which increments each cycle that any valid is high but no ready is asserted.
- Not defined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - ALU control constants: CTL_ZERO=6'b101010, CTL_ONE=6'b111111, CTL_NEG1=6'b111010, CTL_X=6'b001100, CTL_XPLUSY=6'b000010, CTL_XMINUSY=6'b010011, CTL_XANDY=6'b000000, CTL_XORY=6'b010101.
  - State encodings IDLE=1'b0 and HOLD=1'b1.
- One natural sub-module, rr_arb2: 2-way round-robin/fixed-priority grant logic taking valid0, valid1, last_grant, enable and producing grant0, grant1.
- The ALU itself remains external.

Test Plan:
- Reset → rsp_valid=0, rsp_out=0. Then req0 x=5, y=3, ctl=CTL_XPLUSY, rsp_ready=1 → req0_ready in cycle t; cycle t+1: rsp_out=8, zr=0, ng=0, rsp_id=0.
- Both valid every cycle:
  - req0 (x=10, y=4, CTL_XMINUSY); req1 (x=4, y=10, CTL_XMINUSY); rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - Responses alternate 6 (id0) and 0xFFFA with ng=1 (id1), one per cycle.
- Backpressure:
  - rsp_ready=0 for 3 cycles after a CTL_ZERO op → rsp_out=0, zr=1 held.
  - Both readies stay 0 throughout.
  - Raising rsp_ready grants the next request in that same cycle.
- RR=0 with both valid → req0 granted every cycle and req1 starves. Dropping req0_valid → req1 granted next cycle.
- Reset asserted in HOLD with rsp_ready=0 → next cycle rsp_valid=0, last_grant=1. With both then valid, req0 wins first.
- ALU_SHARE_STATS_EN:
  - 0x10000 req1 handshakes → grant_cnt1 wraps to 0.
  - 2 stalled cycles → stall_cnt=2.
